// File: rtl/mul_sequencer.sv
// Iterative shift-add 64-bit multiply controller that borrows the execute-stage ALU adder.
// Optional macro MUL_EARLY_EXIT_EN: stop iterating once no set multiplier bits remain.
module mul_sequencer #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         flush,
    input  logic [N-1:0] multiplicand,
    input  logic [N-1:0] multiplier,
    input  logic [N-1:0] alu_result,
    output logic         alu_own,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_control,
    output logic         stall,
    output logic         done,
    output logic [N-1:0] product
);

    localparam int         CNT_W   = (N > 1) ? $clog2(N) : 1;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_NOP = 4'b0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       acc_q, acc_d;
    logic [N-1:0]       mcand_q, mcand_d;
    logic [N-1:0]       mplier_q, mplier_d;
    logic [N-1:0]       product_q, product_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_iter;
    logic               start_acc;

    assign start_acc = start && !flush;

`ifdef MUL_EARLY_EXIT_EN
    // Once the shifted multiplier runs out of set bits, the remaining adds are all no-ops.
    assign last_iter = ((mplier_q >> 1) == '0) || (cnt_q == CNT_W'(N - 1));
`else
    assign last_iter = (cnt_q == CNT_W'(N - 1));
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        alu_own   = 1'b0;
        stall     = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_acc) begin
                    acc_d    = '0;
                    mcand_d  = multiplicand;
                    mplier_d = multiplier;
                    cnt_d    = '0;
                    state_d  = S_ITER;
`ifdef MUL_EARLY_EXIT_EN
                    if (multiplier == '0) begin
                        state_d = S_DONE;
                    end
`endif
                end
            end

            S_ITER: begin
                alu_own = 1'b1;
                stall   = 1'b1;
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = alu_result;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (last_iter) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                // Pipeline stays held through this cycle even when a flush kills the result.
                stall   = 1'b1;
                state_d = S_IDLE;
                if (!flush) begin
                    done      = 1'b1;
                    product_d = acc_q;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ALU operand mux is gated so the execute stage sees zeros whenever it owns the ALU.
    assign alu_a       = alu_own ? acc_q   : '0;
    assign alu_b       = alu_own ? mcand_q : '0;
    assign alu_control = alu_own ? ALU_ADD : ALU_NOP;
    assign product     = product_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: directed and random multiplies against a plain-arithmetic model.
module tb_mul_sequencer;

    localparam int N = 64;
`ifdef MUL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         flush;
    logic [N-1:0] multiplicand;
    logic [N-1:0] multiplier;
    logic [N-1:0] alu_result;
    logic         alu_own;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_control;
    logic         stall;
    logic         done;
    logic [N-1:0] product;

    int           errors = 0;
    int           checks = 0;
    logic [N-1:0] last_prod;

    mul_sequencer #(.N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .flush        (flush),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .alu_result   (alu_result),
        .alu_own      (alu_own),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_control  (alu_control),
        .stall        (stall),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    // Execute-stage ALU: adds on 4'b0010, otherwise produces zero.
    always_comb alu_result = (alu_control == 4'b0010) ? (alu_a + alu_b) : '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_latency(input logic [N-1:0] b);
        int hi;
        hi = -1;
        for (int i = 0; i < N; i++) begin
            if (b[i]) hi = i;
        end
        return EARLY ? (hi + 2) : (N + 1);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, " stall"}, 64'(stall), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
        check({tag, " alu_own"}, 64'(alu_own), 64'd0);
        check({tag, " alu_ctl"}, 64'(alu_control), 64'd0);
        check({tag, " alu_a"}, alu_a, 64'd0);
        check({tag, " alu_b"}, alu_b, 64'd0);
    endtask

    // Called in cycle 0 with the DUT idle; returns with the DUT idle again.
    task automatic run_mul(input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
        int           lat;
        int           done_cyc;
        int           done_cnt;
        int           stall_bad;
        int           own_bad;
        logic [N-1:0] exp;
        lat       = ref_latency(b);
        exp       = a * b;
        done_cyc  = -1;
        done_cnt  = 0;
        stall_bad = 0;
        own_bad   = 0;
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        step();
        start        = 1'b0;
        multiplicand = {$urandom, $urandom};
        multiplier   = {$urandom, $urandom};
        for (int c = 1; c <= lat + 3; c++) begin
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
            end
            if (c <= lat && stall !== 1'b1) stall_bad++;
            if (c > lat && stall !== 1'b0) stall_bad++;
            if (c < lat && (alu_own !== 1'b1 || alu_control !== 4'b0010)) own_bad++;
            if (c >= lat && (alu_own !== 1'b0 || alu_control !== 4'b0000 ||
                             alu_a !== '0 || alu_b !== '0)) own_bad++;
            if (c == 1 && lat > 1) begin
                check({tag, " first alu_a"}, alu_a, 64'd0);
                check({tag, " first alu_b"}, alu_b, a);
            end
            if (c == lat) check({tag, " product held"}, product, last_prod);
            if (c == lat + 1) check({tag, " product"}, product, exp);
            step();
        end
        check({tag, " done count"}, 64'(done_cnt), 64'd1);
        check({tag, " done cycle"}, 64'(done_cyc), 64'(lat));
        check({tag, " stall window"}, 64'(stall_bad), 64'd0);
        check({tag, " alu ownership"}, 64'(own_bad), 64'd0);
        last_prod = exp;
    endtask

    initial begin
        int busy_cyc;
        int flush_cyc;
        int lat;
        int dcount;
        int dcyc;

        busy_cyc  = EARLY ? 2 : 10;
        flush_cyc = EARLY ? 2 : 20;
        last_prod = '0;

        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        step();
        step();
        check_idle_outputs("reset");
        check("reset product", product, 64'd0);
        reset = 1'b0;
        step();

        run_mul(64'd3, 64'd5, "basic");
        run_mul(64'h8000_0000_0000_0000, 64'd2, "wrap_pow2");
        run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "wrap_ones");
        run_mul(64'h1234, 64'd0, "zero_mplier");
        for (int i = 0; i < 6; i++) begin
            run_mul({$urandom, $urandom},
                    (i < 3) ? {$urandom, $urandom} : 64'($urandom_range(0, 255)),
                    "random");
        end

        // Start while busy must be ignored.
        lat = ref_latency(64'd6);
        multiplicand = 64'd7;
        multiplier   = 64'd6;
        start        = 1'b1;
        step();
        start  = 1'b0;
        dcount = 0;
        dcyc   = -1;
        for (int c = 1; c <= N + 10; c++) begin
            if (done === 1'b1) begin
                dcount++;
                dcyc = c;
            end
            start        = (c == busy_cyc);
            multiplicand = 64'd11;
            multiplier   = 64'd13;
            step();
        end
        start = 1'b0;
        check("busy done count", 64'(dcount), 64'd1);
        check("busy done cycle", 64'(dcyc), 64'(lat));
        check("busy product", product, 64'd42);
        check("busy no second op", 64'(stall), 64'd0);
        last_prod = 64'd42;

        // Flush in the middle of the iterations.
        multiplicand = 64'd9;
        multiplier   = 64'd9;
        start        = 1'b1;
        step();
        start  = 1'b0;
        dcount = 0;
        for (int c = 1; c <= flush_cyc; c++) begin
            if (done === 1'b1) dcount++;
            if (c == flush_cyc) begin
                flush = 1'b1;
                check("flush cycle stall", 64'(stall), 64'd1);
            end
            step();
        end
        flush = 1'b0;
        check_idle_outputs("after flush");
        check("flush no done", 64'(dcount), 64'd0);
        check("flush product kept", product, last_prod);
        run_mul(64'd9, 64'd9, "after_flush");

        // Flush landing on the done cycle suppresses the pulse and the update.
        lat = ref_latency(64'd5);
        multiplicand = 64'd5;
        multiplier   = 64'd5;
        start        = 1'b1;
        step();
        start  = 1'b0;
        dcount = 0;
        for (int c = 1; c < lat; c++) begin
            if (done === 1'b1) dcount++;
            step();
        end
        flush = 1'b1;
        #1;
        check("flush at done pulse", 64'(done), 64'd0);
        check("flush at done stall", 64'(stall), 64'd1);
        step();
        flush = 1'b0;
        check("flush at done early pulse", 64'(dcount), 64'd0);
        check("flush at done product", product, last_prod);
        check("flush at done stall after", 64'(stall), 64'd0);

        // Reset in the middle of an operation clears everything, product included.
        multiplicand = 64'h55;
        multiplier   = 64'h8000_0000_0000_0001;
        start        = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 30; c++) step();
        check("pre-reset stall", 64'(stall), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle_outputs("mid reset");
        check("mid reset product", product, 64'd0);
        last_prod = '0;

        // start and flush together in IDLE capture nothing.
        multiplicand = 64'd3;
        multiplier   = 64'd3;
        start        = 1'b1;
        flush        = 1'b1;
        step();
        start  = 1'b0;
        flush  = 1'b0;
        dcount = 0;
        for (int c = 0; c < 5; c++) begin
            if (done === 1'b1 || stall !== 1'b0 || alu_own !== 1'b0) dcount++;
            step();
        end
        check("start+flush ignored", 64'(dcount), 64'd0);
        run_mul(64'd6, 64'd7, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

endmodule
